rv_g_instenc: RTL and testbench
===============================

RV_G_INSTENC -- requirements
Module: rv_g_instenc

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries, power of two, 2..8.
REQ-002 SHALL have parameter ERR_CNT_W, default 16: width of the error counter.
REQ-003 SHALL have ports clk_i (input, 1, clock) and arst_ni (input, 1, reset), with one clock and an asynchronous, active-low reset.
REQ-004 SHALL have in_valid_i (input, 1): the input fields are valid.
REQ-005 SHALL have in_ready_o (output, 1): the encoder accepts an input this cycle.
REQ-006 SHALL have fmt_i (input, 3): 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6..7 illegal.
REQ-007 SHALL have opcode_i (input, 7), funct3_i (input, 3) and funct7_i (input, 7).
REQ-008 SHALL have rd_i, rs1_i and rs2_i (input, 5 each): register indices.
REQ-009 SHALL have imm_i (input, 32): signed byte-offset or immediate value.
REQ-010 SHALL have out_valid_o (output, 1), out_ready_i (input, 1), code_o (output, 32: encoded word) and err_o (output, 1: encoding error for this word).
REQ-011 SHALL have err_cnt_o (output, ERR_CNT_W): saturating count of errored encodings.

Function
REQ-012 SHALL accept an input when in_valid_i && in_ready_o at a rising clk_i edge.
REQ-013 SHALL drive in_ready_o from the registered occupancy, high iff occupancy < FIFO_DEPTH, with no combinational path from out_ready_i.
REQ-014 SHALL encode with the fields listed MSB to LSB as follows:
  R: funct7|rs2|rs1|f3|rd|op
  I: imm[11:0]|rs1|f3|rd|op
  S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  U: imm[31:12]|rd|op
  J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
REQ-015 SHALL set err for an accepted input when any of these holds:
  - I or S with imm outside [-2048, 2047];
  - B with imm outside [-4096, 4094] or imm[0]=1;
  - J with imm outside [-2^20, 2^20-2] or imm[0]=1;
  - U with imm[11:0] != 0;
  - fmt 6 or 7.
REQ-016 SHALL, on error, still push the word: code = 0x00000000 and err = 1.
REQ-017 SHALL, on error, leave the ordering of words unchanged.
REQ-018 SHALL have latency of exactly 1 cycle: a word accepted at edge N is visible at code_o/out_valid_o after edge N when the buffer was empty.
REQ-019 SHALL hold the output FIFO's pushed {code, err} pairs in acceptance order.
REQ-020 SHALL drive out_valid_o = (occupancy != 0), and code_o/err_o from the head entry.
REQ-021 SHALL pop the head on out_valid_o && out_ready_i.
REQ-022 SHALL hold code_o/err_o stable while out_valid_o && !out_ready_i.
REQ-023 SHALL, on a simultaneous push and pop, keep occupancy unchanged and keep the order correct.
REQ-024 SHALL make the read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL drive code_o = 0 and err_o = 0 when the buffer is empty.
REQ-026 SHALL increment err_cnt_o by 1 on each accepted errored input and saturate at all-ones.
REQ-027 SHALL NOT count err_cnt_o on an output pop.
REQ-028 SHALL ignore all inputs while in_valid_i=0, and SHALL NOT accept an input when in_ready_o=0.

Reset
REQ-029 SHALL, while arst_ni=0, asynchronously clear the occupancy, pointers and err_cnt_o.
REQ-030 SHALL, while arst_ni=0, drive out_valid_o=0, code_o=0 and err_o=0.
REQ-031 SHALL force in_ready_o=0 while arst_ni=0, and SHALL drive it high from the first edge after release.
REQ-032 SHALL, on reset mid-operation, discard all buffered words, with no partial pops or stale outputs after release.

Verification
REQ-033 SHALL cover: I, opcode 0x13, f3 0, rd 1, rs1 0, imm 5 -> code_o 0x00500093, err_o 0, one cycle after accept.
REQ-034 SHALL cover: R, opcode 0x33, f7 0, rs2 2, rs1 1, rd 3 -> 0x002081B3, then S sw (opcode 0x23, f3 2, rs2 2, rs1 1, imm 8) -> 0x0020A423, in order.
REQ-035 SHALL cover: J, opcode 0x6F, rd 1, imm 8 -> 0x008000EF, then U, opcode 0x37, rd 5, imm 0x12345000 -> 0x123452B7.
REQ-036 SHALL cover: B with imm 3, then I with imm 2048, then fmt 7 -> three words with code 0 and err 1, and err_cnt_o=3.
REQ-037 SHALL cover backpressure: out_ready_i=0 with 3 valid inputs -> in_ready_o low after 2 accepts with code_o held; then out_ready_i=1 -> all 3 words in order, with no loss or duplication.
REQ-038 SHALL cover a random round trip: 10k legal random inputs with random out_ready_i, each code_o fed to rv_g_instdec -> decoded fields match the inputs; plus arst_ni pulse mid-stream -> out_valid_o=0, err_cnt_o=0.

Source files
------------

// File: rtl/rv_g_instenc.sv
// RV32 base-format instruction encoder with a small output FIFO and an error counter.
// Illegal field combinations still produce a word (code 0, err 1), so output order is preserved.
module rv_g_instenc #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned ERR_CNT_W  = 16
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [2:0]           fmt_i,
   input  logic [6:0]           opcode_i,
   input  logic [2:0]           funct3_i,
   input  logic [6:0]           funct7_i,
   input  logic [4:0]           rd_i,
   input  logic [4:0]           rs1_i,
   input  logic [4:0]           rs2_i,
   input  logic [31:0]          imm_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [31:0]          code_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

   localparam logic signed [31:0] Imm12Min = -32'sd2048;
   localparam logic signed [31:0] Imm12Max = 32'sd2047;
   localparam logic signed [31:0] BrMin    = -32'sd4096;
   localparam logic signed [31:0] BrMax    = 32'sd4094;
   localparam logic signed [31:0] JmpMin   = -32'sd1048576;
   localparam logic signed [31:0] JmpMax   = 32'sd1048574;

   logic signed [31:0]   imm_s;
   logic [31:0]          enc_code;
   logic                 enc_err;
   logic                 push, pop;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 rdy_q;
   logic [32:0]          mem_q [FIFO_DEPTH];
   logic [32:0]          head;

   assign imm_s = $signed(imm_i);

   always_comb begin
      enc_code = '0;
      enc_err  = 1'b0;
      case (fmt_i)
         3'd0: enc_code = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         3'd1: begin
            enc_err  = (imm_s < Imm12Min) || (imm_s > Imm12Max);
            enc_code = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
         end
         3'd2: begin
            enc_err  = (imm_s < Imm12Min) || (imm_s > Imm12Max);
            enc_code = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         end
         3'd3: begin
            enc_err  = (imm_s < BrMin) || (imm_s > BrMax) || imm_i[0];
            enc_code = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                        opcode_i};
         end
         3'd4: begin
            enc_err  = (imm_i[11:0] != 12'd0);
            enc_code = {imm_i[31:12], rd_i, opcode_i};
         end
         3'd5: begin
            enc_err  = (imm_s < JmpMin) || (imm_s > JmpMax) || imm_i[0];
            enc_code = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
         end
         default: enc_err = 1'b1;
      endcase
      if (enc_err) enc_code = '0;
   end

   // Ready depends only on registered state; rdy_q holds it low until the first edge after reset.
   assign in_ready_o  = rdy_q && (cnt_q < FullCnt);
   assign out_valid_o = (cnt_q != '0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   assign head        = mem_q[rptr_q];
   assign code_o      = out_valid_o ? head[32:1] : '0;
   assign err_o       = out_valid_o ? head[0] : 1'b0;
   assign err_cnt_o   = err_cnt_q;

   always_comb begin
      cnt_d     = cnt_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      err_cnt_d = err_cnt_q;
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      if (push && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (!push && pop) cnt_d = cnt_q - CntW'(1);
      if (push && enc_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         err_cnt_q <= '0;
         rdy_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         err_cnt_q <= err_cnt_d;
         rdy_q     <= 1'b1;
      end
   end

   // Storage needs no reset: outputs are gated by occupancy.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= {enc_code, enc_err};
   end

endmodule

// File: tb/tb_rv_g_instenc.sv
// Self-checking bench for rv_g_instenc: directed encodings, backpressure, and a randomized
// round trip where each output word is decoded back to its fields and compared with the input.
module tb_rv_g_instenc;

   localparam int unsigned Depth = 2;
   localparam int unsigned CntW  = 16;

   logic            clk_i = 1'b0;
   logic            arst_ni = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [2:0]      fmt_i = '0;
   logic [6:0]      opcode_i = '0;
   logic [2:0]      funct3_i = '0;
   logic [6:0]      funct7_i = '0;
   logic [4:0]      rd_i = '0, rs1_i = '0, rs2_i = '0;
   logic [31:0]     imm_i = '0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b0;
   logic [31:0]     code_o;
   logic            err_o;
   logic [CntW-1:0] err_cnt_o;

   rv_g_instenc #(.FIFO_DEPTH(Depth), .ERR_CNT_W(CntW)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
      .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .code_o(code_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        err;
   } txn_t;

   txn_t            q[$];
   int              checks = 0;
   int              failures = 0;
   int              n_acc = 0;
   logic [CntW-1:0] ecnt = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Error rules straight from the format limits, evaluated on the signed immediate.
   function automatic logic spec_err(input txn_t t);
      longint v = longint'($signed(t.imm));
      case (t.fmt)
         3'd0:       return 1'b0;
         3'd1, 3'd2: return (v < -2048) || (v > 2047);
         3'd3:       return (v < -4096) || (v > 4094) || t.imm[0];
         3'd4:       return t.imm[11:0] != 12'd0;
         3'd5:       return (v < -(64'sd1 <<< 20)) || (v > (64'sd1 <<< 20) - 2) || t.imm[0];
         default:    return 1'b1;
      endcase
   endfunction

   // Canonical {op,f3,f7,rd,rs1,rs2,imm}, fields a format does not carry forced to zero.
   function automatic logic [63:0] fields_of(input txn_t t);
      case (t.fmt)
         3'd0:       return {t.op, t.f3, t.f7, t.rd, t.rs1, t.rs2, 32'd0};
         3'd1:       return {t.op, t.f3, 7'd0, t.rd, t.rs1, 5'd0, t.imm};
         3'd2, 3'd3: return {t.op, t.f3, 7'd0, 5'd0, t.rs1, t.rs2, t.imm};
         default:    return {t.op, 3'd0, 7'd0, t.rd, 10'd0, t.imm};
      endcase
   endfunction

   function automatic logic [63:0] decode(input logic [2:0] fmt, input logic [31:0] c);
      logic [31:0] imm;
      case (fmt)
         3'd0: return {c[6:0], c[14:12], c[31:25], c[11:7], c[19:15], c[24:20], 32'd0};
         3'd1: begin
            imm = {{20{c[31]}}, c[31:20]};
            return {c[6:0], c[14:12], 7'd0, c[11:7], c[19:15], 5'd0, imm};
         end
         3'd2: begin
            imm = {{20{c[31]}}, c[31:25], c[11:7]};
            return {c[6:0], c[14:12], 7'd0, 5'd0, c[19:15], c[24:20], imm};
         end
         3'd3: begin
            imm = {{19{c[31]}}, c[31], c[7], c[30:25], c[11:8], 1'b0};
            return {c[6:0], c[14:12], 7'd0, 5'd0, c[19:15], c[24:20], imm};
         end
         3'd4: return {c[6:0], 10'd0, c[11:7], 10'd0, c[31:12], 12'd0};
         default: begin
            imm = {{11{c[31]}}, c[31], c[19:12], c[20], c[30:21], 1'b0};
            return {c[6:0], 10'd0, c[11:7], 10'd0, imm};
         end
      endcase
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      int   v;
      t.fmt = 3'($urandom_range(0, 5));
      t.op  = 7'($urandom);
      t.f3  = 3'($urandom);
      t.f7  = 7'($urandom);
      t.rd  = 5'($urandom);
      t.rs1 = 5'($urandom);
      t.rs2 = 5'($urandom);
      case (t.fmt)
         3'd1, 3'd2: t.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
         3'd3: begin
            v = int'($urandom_range(0, 4095)) - 2048;
            t.imm = 32'(v * 2);
         end
         3'd4: t.imm = $urandom() & 32'hFFFF_F000;
         3'd5: begin
            v = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
            t.imm = 32'(v * 2);
         end
         default: t.imm = $urandom();
      endcase
      if ($urandom_range(0, 15) == 0) begin
         case ($urandom_range(0, 3))
            0:       t.fmt = 3'($urandom_range(6, 7));
            1:       begin t.fmt = 3'd3; t.imm[0] = 1'b1; end
            2:       begin t.fmt = 3'd1; t.imm = 32'd2048 + $urandom_range(0, 100); end
            default: begin t.fmt = 3'd4; t.imm[11:0] = 12'($urandom_range(1, 4095)); end
         endcase
      end
      t.err = spec_err(t);
      return t;
   endfunction

   task automatic drive(input txn_t t, input logic vin);
      in_valid_i = vin;
      fmt_i = t.fmt; opcode_i = t.op; funct3_i = t.f3; funct7_i = t.f7;
      rd_i = t.rd; rs1_i = t.rs1; rs2_i = t.rs2; imm_i = t.imm;
   endtask

   // One cycle against the model; called at posedge+1.
   task automatic step(input txn_t t, input logic vin, input logic ordy);
      txn_t h;
      check_eq("in_ready", {63'd0, in_ready_o}, {63'd0, q.size() < Depth});
      check_eq("out_valid", {63'd0, out_valid_o}, {63'd0, q.size() != 0});
      check_eq("err_cnt", {48'd0, err_cnt_o}, {48'd0, ecnt});
      if (q.size() == 0) check_eq("empty_out", {31'd0, code_o, err_o}, 64'd0);
      drive(t, vin);
      out_ready_i = ordy;
      if (out_valid_o && ordy && q.size() != 0) begin
         h = q.pop_front();
         if (h.err) begin
            check_eq("err_word", {31'd0, code_o, err_o}, 64'd1);
         end else begin
            check_eq("roundtrip", decode(h.fmt, code_o), fields_of(h));
            check_eq("word_err", {63'd0, err_o}, 64'd0);
         end
      end
      if (vin && in_ready_o) begin
         q.push_back(t);
         n_acc++;
         if (t.err && ecnt != '1) ecnt++;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
      txn_t t;
      t.fmt = fmt; t.op = op; t.f3 = f3; t.f7 = f7; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
      t.imm = imm; t.err = 1'b0;
      drive(t, 1'b1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   initial begin
      txn_t t;
      int   cyc;
      #3;
      check_eq("rst_ready", {63'd0, in_ready_o}, 64'd0);
      check_eq("rst_out", {30'd0, out_valid_o, code_o, err_o}, 64'd0);
      check_eq("rst_errcnt", {48'd0, err_cnt_o}, 64'd0);
      #9 arst_ni = 1'b1;
      #1 check_eq("ready_pre_edge", {63'd0, in_ready_o}, 64'd0);
      @(posedge clk_i);
      #1 check_eq("ready_after_edge", {63'd0, in_ready_o}, 64'd1);

      out_ready_i = 1'b1;
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      check_eq("addi", {31'd0, out_valid_o, code_o}, {31'd0, 1'b1, 32'h0050_0093});
      check_eq("addi_err", {63'd0, err_o}, 64'd0);
      send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
      check_eq("add", {32'd0, code_o}, 64'h0020_81B3);
      send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
      check_eq("sw", {32'd0, code_o}, 64'h0020_A423);
      send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
      check_eq("jal", {32'd0, code_o}, 64'h0080_00EF);
      send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      check_eq("lui", {32'd0, code_o}, 64'h1234_52B7);
      send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
      check_eq("b_odd", {31'd0, code_o, err_o}, 64'd1);
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      check_eq("i_range", {31'd0, code_o, err_o}, 64'd1);
      send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
      check_eq("fmt7", {31'd0, code_o, err_o}, 64'd1);
      @(posedge clk_i);
      #1;
      check_eq("err_cnt3", {48'd0, err_cnt_o}, 64'd3);
      check_eq("drained", {30'd0, out_valid_o, code_o, err_o}, 64'd0);

      // Backpressure: two accepts fill the buffer, the third waits.
      out_ready_i = 1'b0;
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
      check_eq("bp_full", {63'd0, in_ready_o}, 64'd0);
      check_eq("bp_head", {32'd0, code_o}, 64'h0010_0093);
      in_valid_i = 1'b1;
      imm_i = 32'd3;
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("bp_hold", {31'd0, in_ready_o, code_o}, 64'h0010_0093);
      out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_eq("bp_pop1", {32'd0, code_o}, 64'h0020_0093);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      check_eq("bp_pop2", {32'd0, code_o}, 64'h0030_0093);
      @(posedge clk_i);
      #1;
      check_eq("bp_empty", {63'd0, out_valid_o}, 64'd0);

      ecnt = err_cnt_o == 16'd3 ? 16'd3 : 16'd3;
      cyc = 0;
      while (n_acc < 10000 && cyc < 40000) begin
         if (cyc == 7000) begin
            in_valid_i = 1'b0;
            arst_ni = 1'b0;
            #1;
            check_eq("mid_rst", {30'd0, out_valid_o, code_o, err_o}, 64'd0);
            check_eq("mid_rst_cnt", {47'd0, in_ready_o, err_cnt_o}, 64'd0);
            @(posedge clk_i);
            #3 arst_ni = 1'b1;
            q.delete();
            ecnt = '0;
            check_eq("mid_rst_ready", {63'd0, in_ready_o}, 64'd0);
            @(posedge clk_i);
            #1;
         end
         t = rand_txn();
         step(t, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         cyc++;
      end
      check_eq("accepted", {63'd0, n_acc >= 10000}, 64'd1);
      t = rand_txn();
      repeat (Depth + 2) step(t, 1'b0, 1'b1);
      check_eq("final_empty", {63'd0, out_valid_o}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
